// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
// Strips preamble/SFD from a GMII receive stream and emits the frame bytes as a
// valid/sof/eof byte stream through a 5-stage delay line. CRC-32, length and
// gmii_er are checked per frame, an rtclock timestamp is latched at SFD and
// good/bad frame counters are kept.
// Build option: define GMII_RX_STRIP_FCS_EN to drop the 4 FCS bytes from the
// output stream (eof/err then ride on the last payload byte).
module gmii_rx_deframer #(
    parameter int unsigned C_MIN_FRAME_LEN = 32'd64,
    parameter int unsigned C_MAX_FRAME_LEN = 32'd1518
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  gmii_d,
    input  logic        gmii_en,
    input  logic        gmii_er,
    input  logic [47:0] sec,
    input  logic [29:0] nsec,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sof,
    output logic        m_eof,
    output logic        m_err,
    output logic [47:0] ts_sec,
    output logic [29:0] ts_nsec,
    output logic [31:0] frames_ok,
    output logic [31:0] frames_bad
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // Reflected CRC-32 update, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ d[i]) == 1'b1) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t          state_r, state_s;
    logic            sfd_s, push_s, eof_s, bad_s, direct_bad_s;
    logic [31:0]     crc_r;
    logic [15:0]     len_r;
    logic            er_seen_r;

    // Delay line: index 0 is stage 1 (newest), index 4 is stage 5 (oldest).
    logic [4:0]      dl_valid_r, dl_sof_r, dl_eof_r, dl_err_r;
    logic [4:0][7:0] dl_data_r;
    logic [4:0]      nx_valid_s, nx_sof_s, nx_eof_s, nx_err_s;
    logic [4:0][7:0] nx_data_s;
    logic            out_valid_s, out_sof_s, out_eof_s, out_err_s;
    logic [7:0]      out_data_s;
    logic            ok_inc_s, bad_inc_s;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and per-cycle frame events (SFD, data push, end of frame).
    always_comb begin
        state_s = state_r;
        sfd_s   = 1'b0;
        push_s  = 1'b0;
        eof_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_PREAMBLE: begin
                if (!gmii_en) begin
                    state_s = ST_IDLE;
                end else if (gmii_d == 8'h55) begin
                    state_s = ST_PREAMBLE;
                end else if (gmii_d == 8'hD5) begin
                    state_s = ST_DATA;
                    sfd_s   = 1'b1;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_DATA: begin
                if (gmii_en) begin
                    push_s  = 1'b1;
                    state_s = ST_DATA;
                end else begin
                    eof_s   = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!gmii_en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Per-frame CRC, saturating length and sticky error, restarted at SFD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_r     <= CRC_INIT;
            len_r     <= 16'd0;
            er_seen_r <= 1'b0;
        end else if (sfd_s) begin
            crc_r     <= CRC_INIT;
            len_r     <= 16'd0;
            er_seen_r <= 1'b0;
        end else if (push_s) begin
            crc_r     <= crc32_byte(crc_r, gmii_d);
            len_r     <= (len_r == 16'hFFFF) ? len_r : len_r + 16'd1;
            er_seen_r <= er_seen_r | gmii_er;
        end
    end

    // Frame verdict, valid on the end-of-frame cycle.
    always_comb begin
        bad_s = (crc_r != CRC_RESIDUE) | er_seen_r |
                ({16'd0, len_r} < C_MIN_FRAME_LEN) |
                ({16'd0, len_r} > C_MAX_FRAME_LEN);
    end

    // Delay-line shift plus end-of-frame tagging of the right entry.
    always_comb begin
        nx_valid_s   = {dl_valid_r[3:0], push_s};
        nx_data_s    = {dl_data_r[3:0], (push_s ? gmii_d : 8'h00)};
        nx_sof_s     = {dl_sof_r[3:0], (push_s & (len_r == 16'd0))};
        nx_eof_s     = {dl_eof_r[3:0], 1'b0};
        nx_err_s     = {dl_err_r[3:0], 1'b0};
        out_valid_s  = dl_valid_r[4];
        out_data_s   = dl_data_r[4];
        out_sof_s    = dl_sof_r[4];
        out_eof_s    = dl_eof_r[4];
        out_err_s    = dl_err_r[4];
        direct_bad_s = 1'b0;
`ifdef GMII_RX_STRIP_FCS_EN
        // FCS sits in stages 1-4: discard it, close the frame on stage 5.
        if (eof_s) begin
            nx_valid_s = 5'b0_0000;
            nx_data_s  = {5{8'h00}};
            nx_sof_s   = 5'b0_0000;
            nx_eof_s   = 5'b0_0000;
            nx_err_s   = 5'b0_0000;
            if (dl_valid_r[4]) begin
                out_eof_s = 1'b1;
                out_err_s = bad_s;
            end else begin
                direct_bad_s = 1'b1;
            end
        end else begin
            direct_bad_s = 1'b0;
        end
`else
        // Last FCS byte is in stage 1: tag it as it moves into stage 2.
        if (eof_s) begin
            if (dl_valid_r[0]) begin
                nx_eof_s[1] = 1'b1;
                nx_err_s[1] = bad_s;
            end else begin
                direct_bad_s = 1'b1;
            end
        end else begin
            direct_bad_s = 1'b0;
        end
`endif
        ok_inc_s  = out_valid_s & out_eof_s & ~out_err_s;
        bad_inc_s = out_valid_s & out_eof_s & out_err_s;
    end

    // Delay-line registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dl_valid_r <= 5'b0_0000;
            dl_data_r  <= {5{8'h00}};
            dl_sof_r   <= 5'b0_0000;
            dl_eof_r   <= 5'b0_0000;
            dl_err_r   <= 5'b0_0000;
        end else begin
            dl_valid_r <= nx_valid_s;
            dl_data_r  <= nx_data_s;
            dl_sof_r   <= nx_sof_s;
            dl_eof_r   <= nx_eof_s;
            dl_err_r   <= nx_err_s;
        end
    end

    // Output stream register; counters step on the same edge as m_eof.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid    <= 1'b0;
            m_data     <= 8'h00;
            m_sof      <= 1'b0;
            m_eof      <= 1'b0;
            m_err      <= 1'b0;
            frames_ok  <= 32'd0;
            frames_bad <= 32'd0;
        end else begin
            m_valid    <= out_valid_s;
            m_data     <= out_data_s;
            m_sof      <= out_sof_s;
            m_eof      <= out_eof_s;
            m_err      <= out_err_s;
            frames_ok  <= frames_ok + {31'd0, ok_inc_s};
            frames_bad <= frames_bad + {31'd0, bad_inc_s} + {31'd0, direct_bad_s};
        end
    end

    // Timestamp captured on the SFD edge and held until the next SFD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_sec  <= 48'd0;
            ts_nsec <= 30'd0;
        end else if (sfd_s) begin
            ts_sec  <= sec;
            ts_nsec <= nsec;
        end
    end

endmodule
